// File: rtl/mem_arbiter.sv
// Two-requester (core/host) arbiter for the shared single-port memory, with locked host bursts
// capped at LOCK_MAX grants while the other side waits. Define MEM_ARB_FIXED_PRIO_EN for core-priority arbitration.
module mem_arbiter #(
   parameter int INSTR_SIZE = 16,
   parameter int DATA_SIZE  = 8,
   parameter int ADDR_SIZE  = 5,
   parameter int LOCK_MAX   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  core_req,
   input  logic                  core_we,
   input  logic [ADDR_SIZE-1:0]  core_addr,
   input  logic [DATA_SIZE-1:0]  core_wdata,
   input  logic                  core_lock,
   input  logic                  host_req,
   input  logic                  host_we,
   input  logic [ADDR_SIZE-1:0]  host_addr,
   input  logic [DATA_SIZE-1:0]  host_wdata,
   input  logic                  host_lock,
   output logic                  core_gnt,
   output logic                  host_gnt,
   output logic                  core_rvalid,
   output logic                  host_rvalid,
   output logic [INSTR_SIZE-1:0] core_rdata,
   output logic [INSTR_SIZE-1:0] host_rdata,
   output logic [ADDR_SIZE-1:0]  mem_addr,
   output logic                  mem_we,
   output logic [DATA_SIZE-1:0]  mem_wdata,
   input  logic [INSTR_SIZE-1:0] mem_rdata
);

   localparam int CW = $clog2(LOCK_MAX + 1);
   localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_MAX - 1);
   localparam logic OWN_CORE = 1'b0;
   localparam logic OWN_HOST = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CORE = 2'd1,
      ST_HOST = 2'd2
   } state_t;

   state_t          state_r, state_nxt_s, oth_state_s;
   logic            last_owner_r, last_nxt_s, own_id_s;
   logic [CW-1:0]   lock_cnt_r, cnt_nxt_s;
   logic            own_req_s, own_lock_s, oth_req_s;

   // State, round-robin history and lock-run counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         last_owner_r <= OWN_HOST;
         lock_cnt_r   <= {CW{1'b0}};
      end else begin
         state_r      <= state_nxt_s;
         last_owner_r <= last_nxt_s;
         lock_cnt_r   <= cnt_nxt_s;
      end
   end

   // Present the current owner's and the other requester's controls in owner-relative form
   always_comb begin
      own_req_s   = 1'b0;
      own_lock_s  = 1'b0;
      oth_req_s   = 1'b0;
      oth_state_s = ST_IDLE;
      own_id_s    = OWN_CORE;
      if (state_r == ST_HOST) begin
         own_req_s   = host_req;
         own_lock_s  = host_lock;
         oth_req_s   = core_req;
         oth_state_s = ST_CORE;
         own_id_s    = OWN_HOST;
      end else begin
         own_req_s   = core_req;
         own_lock_s  = core_lock;
         oth_req_s   = host_req;
         oth_state_s = ST_HOST;
         own_id_s    = OWN_CORE;
      end
   end

   // Next-state: idle arbitration, lock holding with starvation cap, ownership hand-over
   always_comb begin
      state_nxt_s = state_r;
      last_nxt_s  = last_owner_r;
      cnt_nxt_s   = lock_cnt_r;
      case (state_r)
         ST_IDLE: begin
            cnt_nxt_s = {CW{1'b0}};
            if (core_req && host_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
               state_nxt_s = ST_CORE;
`else
               state_nxt_s = (last_owner_r == OWN_HOST) ? ST_CORE : ST_HOST;
`endif
            end else if (core_req) begin
               state_nxt_s = ST_CORE;
            end else if (host_req) begin
               state_nxt_s = ST_HOST;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_CORE, ST_HOST: begin
            if (own_req_s && own_lock_s && !oth_req_s) begin
               state_nxt_s = state_r;
            end else if (own_req_s && own_lock_s && (lock_cnt_r < LOCK_LAST)) begin
               cnt_nxt_s = lock_cnt_r + CW'(1);
`ifdef MEM_ARB_FIXED_PRIO_EN
            end else if (own_req_s && (own_id_s == OWN_CORE)) begin
               state_nxt_s = state_r;
`endif
            end else if (oth_req_s) begin
               // covers both plain hand-over and the forced switch at the lock cap
               state_nxt_s = oth_state_s;
               last_nxt_s  = own_id_s;
               cnt_nxt_s   = {CW{1'b0}};
            end else if (own_req_s) begin
               state_nxt_s = state_r;
            end else begin
               state_nxt_s = ST_IDLE;
               last_nxt_s  = own_id_s;
               cnt_nxt_s   = {CW{1'b0}};
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = {CW{1'b0}};
         end
      endcase
   end

   // Grants and memory port follow the owner; everything is zero while idle or in reset
   always_comb begin
      core_gnt  = 1'b0;
      host_gnt  = 1'b0;
      mem_addr  = {ADDR_SIZE{1'b0}};
      mem_wdata = {DATA_SIZE{1'b0}};
      mem_we    = 1'b0;
      case (state_r)
         ST_CORE: begin
            core_gnt  = core_req;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            mem_we    = core_req & core_we;
         end
         ST_HOST: begin
            host_gnt  = host_req;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_we    = host_req & host_we;
         end
         default: begin
            core_gnt = 1'b0;
            host_gnt = 1'b0;
         end
      endcase
   end

   // Registered read return; rdata holds between reads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_rvalid <= 1'b0;
         host_rvalid <= 1'b0;
         core_rdata  <= {INSTR_SIZE{1'b0}};
         host_rdata  <= {INSTR_SIZE{1'b0}};
      end else begin
         core_rvalid <= core_gnt & ~core_we;
         host_rvalid <= host_gnt & ~host_we;
         if (core_gnt && !core_we) begin
            core_rdata <= mem_rdata;
         end
         if (host_gnt && !host_we) begin
            host_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model of ownership, memory contents and read returns.
module tb_mem_arbiter;

`ifdef MEM_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif
   localparam int LOCK_MAX = 4;

   logic        clk, rst_n;
   logic        core_req, core_we, core_lock, host_req, host_we, host_lock;
   logic [4:0]  core_addr, host_addr, mem_addr;
   logic [7:0]  core_wdata, host_wdata, mem_wdata;
   logic        core_gnt, host_gnt, core_rvalid, host_rvalid, mem_we;
   logic [15:0] core_rdata, host_rdata, mem_rdata;

   int vectors = 0;
   int miscompares = 0;

   logic [15:0] mem_arr [32];
   logic [15:0] exp_mem [32];
   logic        mem_ready = 1'b0;

   // reference model: 0 idle, 1 core owns, 2 host owns
   int          m_state, m_last, m_cnt;
   logic        m_crv, m_hrv, e_cg, e_hg;
   logic [15:0] m_crd, m_hrd;

   mem_arbiter #(.INSTR_SIZE(16), .DATA_SIZE(8), .ADDR_SIZE(5), .LOCK_MAX(LOCK_MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_lock(core_lock),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_lock(host_lock),
      .core_gnt(core_gnt), .host_gnt(host_gnt),
      .core_rvalid(core_rvalid), .host_rvalid(host_rvalid),
      .core_rdata(core_rdata), .host_rdata(host_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] init_word(input logic [4:0] a);
      if (a == 5'd3) return 16'hA55A;
      return {3'b101, a, 3'b010, a ^ 5'h1b};
   endfunction

   // memory model: combinational read, byte write into bits [7:0]
   assign mem_rdata = mem_arr[mem_addr];
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 32; i++) mem_arr[i] <= init_word(5'(i));
      end else if (mem_we) begin
         mem_arr[mem_addr][7:0] <= mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero();
      chk("rst_core_gnt", 32'(core_gnt), 32'd0);
      chk("rst_host_gnt", 32'(host_gnt), 32'd0);
      chk("rst_core_rvalid", 32'(core_rvalid), 32'd0);
      chk("rst_host_rvalid", 32'(host_rvalid), 32'd0);
      chk("rst_core_rdata", 32'(core_rdata), 32'd0);
      chk("rst_host_rdata", 32'(host_rdata), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m_state = 0; m_last = 2; m_cnt = 0;
      m_crv = 1'b0; m_hrv = 1'b0; m_crd = 16'd0; m_hrd = 16'd0;
      #2;
      check_zero();
      core_req = 1'b0; host_req = 1'b0; core_lock = 1'b0; host_lock = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // compare all outputs with the model at the falling edge
   task automatic sample();
      logic [4:0] ea;
      logic [7:0] ew;
      logic       ewe;
      @(negedge clk);
      e_cg = (m_state == 1) && core_req;
      e_hg = (m_state == 2) && host_req;
      ea = 5'd0; ew = 8'd0; ewe = 1'b0;
      if (m_state == 1) begin
         ea = core_addr; ew = core_wdata; ewe = e_cg && core_we;
      end else if (m_state == 2) begin
         ea = host_addr; ew = host_wdata; ewe = e_hg && host_we;
      end
      chk("core_gnt", 32'(core_gnt), 32'(e_cg));
      chk("host_gnt", 32'(host_gnt), 32'(e_hg));
      chk("mem_addr", 32'(mem_addr), 32'(ea));
      chk("mem_we", 32'(mem_we), 32'(ewe));
      chk("mem_wdata", 32'(mem_wdata), 32'(ew));
      chk("core_rvalid", 32'(core_rvalid), 32'(m_crv));
      chk("host_rvalid", 32'(host_rvalid), 32'(m_hrv));
      chk("core_rdata", 32'(core_rdata), 32'(m_crd));
      chk("host_rdata", 32'(host_rdata), 32'(m_hrd));
   endtask

   // advance the model by one rising edge
   task automatic tick();
      int         o;
      logic       oreq, olock, xreq, owe, keep;
      logic [4:0] oa;
      logic [7:0] od;
      @(posedge clk);
      m_crv = 1'b0; m_hrv = 1'b0;
      if (m_state == 0) begin
         if (core_req && host_req) m_state = (FIXED || m_last == 2) ? 1 : 2;
         else if (core_req) m_state = 1;
         else if (host_req) m_state = 2;
         m_cnt = 0;
      end else begin
         o     = m_state;
         oreq  = (o == 1) ? core_req   : host_req;
         olock = (o == 1) ? core_lock  : host_lock;
         owe   = (o == 1) ? core_we    : host_we;
         oa    = (o == 1) ? core_addr  : host_addr;
         od    = (o == 1) ? core_wdata : host_wdata;
         xreq  = (o == 1) ? host_req   : core_req;
         if (oreq && owe) exp_mem[oa][7:0] = od;
         if (oreq && !owe) begin
            if (o == 1) begin m_crv = 1'b1; m_crd = exp_mem[oa]; end
            else        begin m_hrv = 1'b1; m_hrd = exp_mem[oa]; end
         end
         keep = oreq && (!xreq || (olock && m_cnt < LOCK_MAX - 1) || (FIXED && o == 1));
         if (oreq && olock && xreq && m_cnt < LOCK_MAX - 1) m_cnt++;
         if (!keep) begin
            m_last = o; m_cnt = 0; m_state = xreq ? 3 - o : 0;
         end
      end
      #1;
   endtask

   task automatic finish_cycle();
      tick();
      if (e_cg) core_req = 1'b0;
      if (e_hg) host_req = 1'b0;
   endtask

   task automatic new_core();
      if ($urandom_range(0, 1) == 1) begin
         core_req = 1'b1; core_we = 1'($urandom_range(0, 1));
         core_addr = 5'($urandom_range(0, 31)); core_wdata = 8'($urandom);
         core_lock = ($urandom_range(0, 3) == 0);
      end else begin
         core_req = 1'b0; core_lock = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic new_host();
      if ($urandom_range(0, 1) == 1) begin
         host_req = 1'b1; host_we = 1'($urandom_range(0, 1));
         host_addr = 5'($urandom_range(0, 31)); host_wdata = 8'($urandom);
         host_lock = ($urandom_range(0, 1) == 1);
      end else begin
         host_req = 1'b0; host_lock = 1'($urandom_range(0, 1));
      end
   endtask

   initial begin
      logic [8:0] hpat, cpat;
      int         hidx, cg_cnt;
      core_req = 1'b0; core_we = 1'b0; core_addr = 5'd0; core_wdata = 8'd0; core_lock = 1'b0;
      host_req = 1'b0; host_we = 1'b0; host_addr = 5'd0; host_wdata = 8'd0; host_lock = 1'b0;
      for (int i = 0; i < 32; i++) exp_mem[i] = init_word(5'(i));
      do_reset();
      mem_ready = 1'b1;

      // core read of word 3 from idle
      core_req = 1'b1; core_we = 1'b0; core_addr = 5'd3;
      sample(); chk("a_gnt_c0", 32'(core_gnt), 32'd0); finish_cycle();
      sample(); chk("a_gnt_c1", 32'(core_gnt), 32'd1); chk("a_addr_c1", 32'(mem_addr), 32'd3); finish_cycle();
      sample(); chk("a_rvalid_c2", 32'(core_rvalid), 32'd1); chk("a_rdata_c2", 32'(core_rdata), 32'hA55A); finish_cycle();
      sample(); finish_cycle();

      // tie after reset: core first, host immediately after
      do_reset();
      core_req = 1'b1; core_we = 1'b0; core_addr = 5'd1;
      host_req = 1'b1; host_we = 1'b0; host_addr = 5'd2; host_lock = 1'b0;
      sample(); finish_cycle();
      sample(); chk("b_core_first", 32'(core_gnt), 32'd1); chk("b_host_wait", 32'(host_gnt), 32'd0); finish_cycle();
      sample(); chk("b_host_next", 32'(host_gnt), 32'd1); chk("b_core_rv", 32'(core_rvalid), 32'd1); finish_cycle();
      sample(); chk("b_host_rv", 32'(host_rvalid), 32'd1); finish_cycle();

      // host locked write burst with core waiting: cap forces one core grant
      host_req = 1'b1; host_we = 1'b1; host_addr = 5'd0; host_wdata = 8'h10; host_lock = 1'b1;
      hidx = 0; cg_cnt = 0; hpat = 9'd0; cpat = 9'd0;
      for (int k = 0; k < 9; k++) begin
         sample();
         hpat[k] = host_gnt; cpat[k] = core_gnt;
         tick();
         if (e_hg) begin
            hidx++;
            if (hidx == 6) begin
               host_req = 1'b0; host_lock = 1'b0;
            end else begin
               host_addr = 5'(hidx); host_wdata = 8'(8'h10 + hidx); host_lock = (hidx < 5);
            end
         end
         if (e_cg) cg_cnt++;
         if (k == 0) begin
            core_req = 1'b1; core_we = 1'b0; core_addr = 5'd7; core_lock = 1'b0;
         end else if (cg_cnt == 2) begin
            core_req = 1'b0;
         end
      end
      chk("c_host_pattern", 32'(hpat), 32'(9'b011011110));
      chk("c_core_pattern", 32'(cpat), 32'(9'b100100000));
      for (int i = 0; i < 6; i++) chk("c_mem_byte", 32'(mem_arr[i][7:0]), 32'(8'h10 + i));
      sample(); finish_cycle();

      // host write then core read-back
      host_req = 1'b1; host_we = 1'b1; host_addr = 5'd9; host_wdata = 8'h7E; host_lock = 1'b0;
      sample(); finish_cycle();
      sample(); finish_cycle();
      core_req = 1'b1; core_we = 1'b0; core_addr = 5'd9; core_lock = 1'b0;
      sample(); finish_cycle();
      sample(); finish_cycle();
      sample(); chk("d_readback", 32'(core_rdata[7:0]), 32'h7E); finish_cycle();

      // reset in the middle of a granted core read
      core_req = 1'b1; core_we = 1'b0; core_addr = 5'd4;
      sample(); finish_cycle();
      sample(); chk("e_gnt_before_rst", 32'(core_gnt), 32'd1);
      do_reset();
      sample(); chk("e_no_rvalid", 32'(core_rvalid), 32'd0); finish_cycle();

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         sample();
         finish_cycle();
         if (!core_req) new_core();
         if (!host_req) new_host();
      end
      core_req = 1'b0; host_req = 1'b0;
      sample(); finish_cycle();
      sample(); finish_cycle();

`ifdef MEM_ARB_FIXED_PRIO_EN
      // fixed priority: continuous core traffic starves unlocked host
      do_reset();
      core_req = 1'b1; core_we = 1'b0; core_addr = 5'd1; core_lock = 1'b0;
      host_req = 1'b1; host_we = 1'b0; host_addr = 5'd2; host_lock = 1'b0;
      sample(); tick();
      for (int k = 0; k < 10; k++) begin
         sample();
         chk("f_core_every_cycle", 32'(core_gnt), 32'd1);
         chk("f_host_starved", 32'(host_gnt), 32'd0);
         tick();
      end
      core_req = 1'b0;
      sample(); finish_cycle();
      sample(); chk("f_host_after_drop", 32'(host_gnt), 32'd1); finish_cycle();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
